// File: rtl/display_scheduler.sv
// Two-digit multiplexed seven-segment scheduler with frame-synchronous value commit.
// Define DISPLAY_SCHEDULER_DEADTIME_EN to insert blanking phases between digits.
module display_scheduler #(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] digit,
  output logic       blank,
  output logic       select0,
  output logic       select1,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

`ifdef DISPLAY_SCHEDULER_DEADTIME_EN
  localparam bit            DEADTIME   = 1'b1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`else
  // Blank states are unreachable here; a stray entry falls through in one cycle.
  localparam bit            DEADTIME   = 1'b0;
  localparam logic [CW-1:0] BLANK_LAST = '0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    disp0_q, disp0_d, disp1_q, disp1_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic          pending_q, pending_d;
  logic          phase_done, enter_show0, accept;
  logic [3:0]    digit_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    phase_done = 1'b0;
    unique case (state_q)
      SHOW0: begin
        phase_done = (cnt_q == SHOW_LAST);
        if (phase_done) state_d = DEADTIME ? BLANK0 : SHOW1;
      end
      BLANK0: begin
        phase_done = (cnt_q == BLANK_LAST);
        if (phase_done) state_d = SHOW1;
      end
      SHOW1: begin
        phase_done = (cnt_q == SHOW_LAST);
        if (phase_done) state_d = DEADTIME ? BLANK1 : SHOW0;
      end
      BLANK1: begin
        phase_done = (cnt_q == BLANK_LAST);
        if (phase_done) state_d = SHOW0;
      end
      default: state_d = SHOW0;
    endcase

    cnt_d       = phase_done ? '0 : cnt_q + 1'b1;
    enter_show0 = phase_done && (state_d == SHOW0);
    accept      = key_valid && key_ready;

    disp0_d    = disp0_q;
    disp1_d    = disp1_q;
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    // Commit and accept are mutually exclusive: accept needs pending low, commit needs it high.
    if (enter_show0 && pending_q) begin
      disp1_d   = disp0_q;
      disp0_d   = pend_val_q;
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d  = 1'b1;
      pend_val_d = key_code;
    end

    unique case (state_d)
      SHOW0:   digit_d = disp0_d;
      SHOW1:   digit_d = disp1_d;
      default: digit_d = digit;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SHOW0;
      cnt_q      <= '0;
      disp0_q    <= '0;
      disp1_q    <= '0;
      pending_q  <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disp0_q    <= disp0_d;
      disp1_q    <= disp1_d;
      pending_q  <= pending_d;
      pend_val_q <= pend_val_d;
    end
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit      <= '0;
      blank      <= 1'b0;
      select0    <= 1'b0;
      select1    <= 1'b1;
      key_ready  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      digit      <= digit_d;
      blank      <= (state_d == BLANK0) || (state_d == BLANK1);
      select0    <= (state_d != SHOW0);
      select1    <= (state_d != SHOW1);
      key_ready  <= ~pending_d;
      frame_tick <= enter_show0;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: frame timing, frame-boundary commit, reset discard.
module tb_display_scheduler;

  localparam int SHOW = 4;
`ifdef DISPLAY_SCHEDULER_DEADTIME_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int FRAME = 2 * SHOW + 2 * BLK;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] digit;
  logic       blank;
  logic       select0;
  logic       select1;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  logic       m_pending;
  logic [3:0] m_pv, m_d0, m_d1, m_digit;

  display_scheduler #(
    .SHOW_CYCLES (SHOW),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .digit     (digit),
    .blank     (blank),
    .select0   (select0),
    .select1   (select1),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_pv      = 4'h0;
    m_d0      = 4'h0;
    m_d1      = 4'h0;
    m_digit   = 4'h0;
    pos       = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"},     digit,          4'h0);
    check({tag, "_blank"},     4'(blank),      4'h0);
    check({tag, "_select0"},   4'(select0),    4'h0);
    check({tag, "_select1"},   4'(select1),    4'h1);
    check({tag, "_key_ready"}, 4'(key_ready),  4'h1);
    check({tag, "_tick"},      4'(frame_tick), 4'h0);
  endtask

  // Expected outputs from the position inside the frame.
  task automatic check_cycle();
    int   p;
    logic s0_on, s1_on, in_blank;
    p        = pos % FRAME;
    s0_on    = (p < SHOW);
    s1_on    = (p >= SHOW + BLK) && (p < 2 * SHOW + BLK);
    in_blank = !s0_on && !s1_on;
    check("select0",    4'(select0),    4'(!s0_on));
    check("select1",    4'(select1),    4'(!s1_on));
    check("blank",      4'(blank),      4'(in_blank));
    check("frame_tick", 4'(frame_tick), 4'((p == 0) && (pos != 0)));
    check("key_ready",  4'(key_ready),  4'(!m_pending));
    check("digit",      digit,          m_digit);
  endtask

  // Predict the effect of the coming rising edge, then sample at the falling edge.
  task automatic step();
    int np;
    bit acc;
    acc = key_valid && !m_pending;
    np  = (pos + 1) % FRAME;
    if (np == 0 && m_pending) begin
      m_d1      = m_d0;
      m_d0      = m_pv;
      m_pending = 1'b0;
    end
    if (acc) begin
      m_pending = 1'b1;
      m_pv      = key_code;
    end
    if (np < SHOW) m_digit = m_d0;
    else if (np >= SHOW + BLK && np < 2 * SHOW + BLK) m_digit = m_d1;
    @(negedge clk);
    pos++;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int p);
    step();
    for (int i = 0; i < FRAME && (pos % FRAME) != p; i++) step();
  endtask

  initial begin
    key_valid = 1'b0;
    key_code  = 4'h0;
    reset     = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");

    // Release; this cycle is SHOW0 cycle 1 with no frame tick.
    reset = 1'b1;
    model_reset();
    check_cycle();
    run(3 * FRAME);

    // Single key mid-SHOW1 shows up at the next frame boundary.
    run_to_phase(SHOW + BLK);
    step();
    key_valid = 1'b1;
    key_code  = 4'h5;
    step();
    key_valid = 1'b0;
    check("ready_low_after_accept", 4'(key_ready), 4'h0);
    run_to_phase(0);
    check("commit5_digit", digit,           4'h5);
    check("commit5_tick",  4'(frame_tick),  4'h1);
    check("commit5_ready", 4'(key_ready),   4'h1);
    run_to_phase(SHOW + BLK);
    check("commit5_disp1", digit, 4'h0);

    // Back-to-back keys commit in consecutive frames.
    run_to_phase(1);
    key_valid = 1'b1;
    key_code  = 4'h3;
    step();
    key_code = 4'hA;
    for (int i = 0; i < 2 * FRAME && m_pv != 4'hA; i++) step();
    key_valid = 1'b0;
    check("a_pending", 4'(key_ready), 4'h0);
    run_to_phase(0);
    check("commitA_disp0", digit, 4'hA);
    run_to_phase(SHOW + BLK);
    check("commitA_disp1", digit, 4'h3);

    // Pending 7 is discarded by a reset in the first dead-time phase.
    run_to_phase(1);
    key_valid = 1'b1;
    key_code  = 4'h7;
    step();
    key_valid = 1'b0;
    check("seven_pending", 4'(key_ready), 4'h0);
    run_to_phase(SHOW);
    step();
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_cycle();
    run(2 * FRAME);
    check("after_reset_digit", digit,          4'h0);
    check("after_reset_tick",  4'(frame_tick), 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 24000, clk cycles each digit is powered per frame (min 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 120, clk cycles of dead time after each digit (min 1).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_valid  input  1  producer offers key_code this cycle.
REQ-006 SHALL have port key_code  input  4  hex value offered by producer.
REQ-007 SHALL have port key_ready  output  1  scheduler can accept a value this cycle.
REQ-008 SHALL have port digit  output  4  value driven to the shared seven-segment decoder.
REQ-009 SHALL have port blank  output  1  high = decoder segments must be forced off.
REQ-010 SHALL have port select0  output  1  active-low PNP enable, display 0 (newest value).
REQ-011 SHALL have port select1  output  1  active-low PNP enable, display 1 (previous value).
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL hold disp0, disp1 (4 bits each), pending flag, pend_val (4 bits), phase counter and 2-bit state.
REQ-014 SHALL sequence states SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0, cyclically.
REQ-015 SHALL stay SHOW_CYCLES cycles in SHOWx and BLANK_CYCLES cycles in BLANKx; counter clears on each transition.
REQ-016 SHALL register all outputs; outputs reflect the current state, no combinational input-to-output path.
REQ-017 SHOW0: select0=0, select1=1, blank=0, digit=disp0.
REQ-018 SHOW1: select0=1, select1=0, blank=0, digit=disp1.
REQ-019 BLANKx: select0=1, select1=1, blank=1, digit holds last value; both selects never low together.
REQ-020 key_ready SHALL equal ~pending.
REQ-021 Accept occurs when key_valid & key_ready; next cycle pending=1, pend_val=key_code.
REQ-022 key_valid while key_ready=0 SHALL be ignored; producer holds value until accepted.
REQ-023 On the transition into SHOW0 with pending=1: disp1<=disp0, disp0<=pend_val, pending<=0 (commit only at frame boundary, no mid-frame tearing).
REQ-024 Committed value SHALL appear on digit in the first SHOW0 cycle of the new frame.
REQ-025 frame_tick SHALL be 1 exactly in the first cycle of every SHOW0.
REQ-026 Commit and accept cannot coincide (key_ready=0 while pending); a value accepted in the commit cycle's following cycle waits for the next frame.
REQ-027 At most one value is committed per frame; back-to-back keys commit in consecutive frames.

Reset
REQ-028 reset low SHALL immediately force: state=SHOW0, counter=0, disp0=disp1=0, pending=0, pend_val=0.
REQ-029 Output reset values: digit=0, blank=0, select0=0, select1=1, key_ready=1, frame_tick=0.
REQ-030 Reset mid-frame SHALL discard pending value; first cycle after release counts as SHOW0 cycle 1 with frame_tick=0.

Configuration
REQ-031 Macro DISPLAY_SCHEDULER_DEADTIME_EN defined: BLANK0/BLANK1 phases present per REQ-014..019.
REQ-032 Macro undefined: sequence is SHOW0 -> SHOW1 -> SHOW0, BLANK_CYCLES ignored, blank constantly 0, selects switch in one edge; frame period = 2*SHOW_CYCLES.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2, macro defined unless noted)
REQ-033 Hold reset low, release -> select0=0, select1=1, digit=0, key_ready=1; select0 rises after 4 cycles; frame period 12 cycles, frame_tick every 12th cycle.
REQ-034 One-cycle key_valid, key_code=0x5 mid-SHOW1 -> key_ready=0 next cycle; at next SHOW0 digit=5, disp1=0, key_ready=1.
REQ-035 Keys 0x3 then 0xA held valid continuously -> 0x3 commits frame N, 0xA accepted after, commits frame N+1; SHOW1 then shows 3.
REQ-036 Every cycle across 3 frames -> never select0=0 and select1=0 together; blank=1 exactly when both selects are 1.
REQ-037 Pending 0x7, assert reset mid-BLANK0 -> pending cleared, disp0=0 after release, 7 never displayed.
REQ-038 Macro undefined -> frame period 8 cycles, blank always 0, selects toggle directly every 4 cycles.
